mux_arb_reg8: RTL and testbench

MUX_ARB_REG8 -- requirements
Module: mux_arb_reg8

---
 rtl/mux_arb_reg8_pkg.sv | 19 +
 rtl/mux16to8.sv | 17 +
 rtl/mux_arb_reg8.sv | 100 ++++++++++
 tb/tb_mux_arb_reg8.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mux_arb_reg8_pkg.sv
// Shared definitions for the two-channel arbitrated output register.
//   WIDTH_DEF : default payload width of every channel
//   state_t   : output-register occupancy (EMPTY = no word held, FULL = word held)
//   sel_t     : channel select encoding (SEL_A = 0, SEL_B = 1)
package mux_arb_reg8_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_t;

endpackage

// File: rtl/mux16to8.sv
// 2:1 payload multiplexer (two WIDTH-bit inputs folded to one output).
//   a : input selected when s = 0
//   b : input selected when s = 1
//   s : select
//   y : selected payload
module mux16to8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux_arb_reg8.sv
// Two-channel round-robin arbiter feeding a single registered output stage.
//   clk, rst            : clock, synchronous active-high reset
//   a_data/a_valid      : channel A offer;  a_ready : A accepted this cycle
//   b_data/b_valid      : channel B offer;  b_ready : B accepted this cycle
//   sel                 : combinational select (granted channel, else last grant)
//   out_data/out_valid  : registered payload and occupancy
//   out_ready           : consumer takes out_data this cycle
//   cnt_a/cnt_b         : wrapping 8-bit counts of accepted transfers
module mux_arb_reg8
  import mux_arb_reg8_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       cnt_a,
  output logic [7:0]       cnt_b
);

  state_t           r_state;
  state_t           w_state_nxt;
  sel_t             r_last;
  sel_t             w_sel;
  logic [WIDTH-1:0] r_out_data;
  logic [7:0]       r_cnt_a;
  logic [7:0]       r_cnt_b;
  logic             w_load_en;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_grant;
  logic [WIDTH-1:0] w_mux_data;

  // rst gates the load enable so no ready is raised during reset.
  assign w_load_en = ~rst & ((r_state == ST_EMPTY) | out_ready);

  // On a tie the channel that did not win last time is granted.
  assign w_grant_a = w_load_en & a_valid & (~b_valid | (r_last == SEL_B));
  assign w_grant_b = w_load_en & b_valid & (~a_valid | (r_last == SEL_A));
  assign w_grant   = w_grant_a | w_grant_b;

  assign w_sel = w_grant_b ? SEL_B : (w_grant_a ? SEL_A : r_last);

  mux16to8 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .a(a_data),
    .b(b_data),
    .s(sel),
    .y(w_mux_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_grant) w_state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !w_grant) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_last     <= SEL_B;
      r_cnt_a    <= '0;
      r_cnt_b    <= '0;
    end else begin
      if (w_grant) begin
        r_out_data <= w_mux_data;
        r_last     <= w_sel;
      end
      if (w_grant_a) r_cnt_a <= r_cnt_a + 8'd1;
      if (w_grant_b) r_cnt_b <= r_cnt_b + 8'd1;
    end
  end

  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;
  assign sel       = w_sel;
  assign out_data  = r_out_data;
  assign out_valid = (r_state == ST_FULL);
  assign cnt_a     = r_cnt_a;
  assign cnt_b     = r_cnt_b;

endmodule

// File: tb/tb_mux_arb_reg8.sv
module tb_mux_arb_reg8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [7:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic       sel;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  always #5 clk = ~clk;

  mux_arb_reg8 #(
    .WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .a_data(a_data),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .b_data(b_data),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .sel(sel),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cnt_a(cnt_a),
    .cnt_b(cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain occupancy flag, last winner, counts, held word,
  // and a queue of words still owed to the consumer.
  bit         m_known = 0;
  bit         m_full  = 0;
  int         m_last  = 1;
  int         m_cnt_a = 0;
  int         m_cnt_b = 0;
  logic [7:0] m_data  = '0;
  logic [7:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every delivery must match the oldest word owed.
  initial begin
    logic [7:0] w;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("scoreboard_unexpected", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          w = sb_q.pop_front();
          check("scoreboard_data", {24'd0, out_data}, {24'd0, w});
        end
      end
    end
  end

  // One cycle: drive inputs, check predictions just before the edge, advance model.
  task automatic step(input bit r, input bit av, input logic [7:0] ad,
                      input bit bv, input logic [7:0] bd, input bit ordy);
    bit         load;
    int         g;
    int         exp_sel;
    logic [7:0] d;
    rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    #3;
    load = !r && (!m_full || ordy);
    g = -1;
    if (load) begin
      if (av && bv)  g = (m_last == 1) ? 0 : 1;
      else if (av)   g = 0;
      else if (bv)   g = 1;
    end
    exp_sel = (g >= 0) ? g : m_last;
    check("a_ready", {31'd0, a_ready}, {31'd0, (g == 0)});
    check("b_ready", {31'd0, b_ready}, {31'd0, (g == 1)});
    if (m_known) begin
      check("sel", {31'd0, sel}, exp_sel);
      check("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      check("out_data", {24'd0, out_data}, {24'd0, m_data});
      check("cnt_a", {24'd0, cnt_a}, m_cnt_a);
      check("cnt_b", {24'd0, cnt_b}, m_cnt_b);
    end
    if (r) begin
      m_known = 1; m_full = 0; m_last = 1; m_cnt_a = 0; m_cnt_b = 0; m_data = '0;
      sb_q.delete();
    end else if (g >= 0) begin
      d = (g == 0) ? ad : bd;
      sb_q.push_back(d);
      m_data = d;
      m_last = g;
      if (g == 0) m_cnt_a = (m_cnt_a + 1) % 256;
      else        m_cnt_b = (m_cnt_b + 1) % 256;
      m_full = 1;
    end else if (m_full && ordy) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset held two cycles with both channels offering.
    step(1, 1, 8'hAA, 1, 8'hBB, 1);
    step(1, 1, 8'hAA, 1, 8'hBB, 1);

    // Tie: alternating grants starting with A.
    for (int unsigned i = 0; i < 4; i++) step(0, 1, 8'h11, 1, 8'h22, 1);
    check("tie_cnt_a", {24'd0, cnt_a}, 32'd2);
    check("tie_cnt_b", {24'd0, cnt_b}, 32'd2);
    step(0, 0, 8'h00, 0, 8'h00, 1);

    // Backpressure on a held 0x5A, then release with A still offering.
    step(0, 1, 8'h5A, 0, 8'h00, 1);
    for (int unsigned i = 0; i < 3; i++) step(0, 1, 8'h33, 0, 8'h00, 0);
    check("bp_hold_data", {24'd0, out_data}, 32'h5A);
    step(0, 1, 8'h33, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0, 8'h00, 1);

    // Drain: single B word then idle.
    step(0, 0, 8'h00, 1, 8'h7F, 1);
    check("drain_valid", {31'd0, out_valid}, 32'd1);
    step(0, 0, 8'h00, 0, 8'h00, 1);
    check("drain_empty", {31'd0, out_valid}, 32'd0);
    step(0, 0, 8'h00, 0, 8'h00, 1);

    // Counter wrap after 256 A transfers from reset.
    step(1, 0, 8'h00, 0, 8'h00, 1);
    for (int unsigned i = 0; i < 256; i++) step(0, 1, 8'($urandom), 0, 8'h00, 1);
    check("wrap_cnt_a", {24'd0, cnt_a}, 32'd0);
    check("wrap_cnt_b", {24'd0, cnt_b}, 32'd0);
    step(0, 0, 8'h00, 0, 8'h00, 1);

    // Reset right after a grant discards the word and its count.
    step(0, 0, 8'h00, 1, 8'h05, 1);
    step(0, 1, 8'hC3, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0, 8'h00, 0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    step(0, 0, 8'h00, 0, 8'h00, 1);

    // Randomised traffic with occasional reset and backpressure.
    for (int unsigned i = 0; i < 3000; i++) begin
      step(($urandom % 60) == 0, 1'($urandom), 8'($urandom), 1'($urandom),
           8'($urandom), ($urandom % 4) != 0);
    end
    step(0, 0, 8'h00, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0, 8'h00, 1);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
